// File: rtl/dmem_pkg.sv
// Shared definitions for the multi-cycle data-memory responder:
// FSM state encoding, word/offset widths and a constant clog2 helper.
package dmem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int WORD_W     = 32;
  localparam int BYTE_OFF_W = 2;

  // Ceiling log2, usable in constant (parameter) expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage for the data-memory responder: one synchronous
// write port and an asynchronous read on the same index. Contents are not
// reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IW          = 8
) (
  input  logic              clock,
  input  logic              we,
  input  logic [IW-1:0]     idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Store the word on the rising edge that closes a committed write.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder on the MEM-stage load/store interface.
// Each request is held for WAIT_CYCLES stall cycles and then completes:
// stores commit at the closing edge, loads return data combinationally on
// the completion cycle. Misaligned, out-of-range and read+write requests
// are flagged on addr_err and never touch memory.
// Optional build macro DMEM_STATS_EN adds read/write/stall counters.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              stall,
  output logic              addr_err
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count,
  output logic [31:0]       stall_count
`endif
);

  // Index width; at least one bit so a single-word memory still elaborates.
  localparam int IW = (clog2(DEPTH_WORDS) < 1) ? 1 : clog2(DEPTH_WORDS);

  // First byte address past the end, compared against the full 32-bit
  // address so high address bits can never alias into the array.
  localparam logic [WORD_W:0] ADDR_LIMIT = (WORD_W + 1)'(DEPTH_WORDS) << BYTE_OFF_W;

  // Counter load value on entering WAIT; unused when WAIT_CYCLES is 0.
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nxt;

  logic              req;
  logic              stall_raw;
  logic              done_raw;
  logic              done;
  logic              fault;
  logic              we;
  logic              rd_ok;
  logic [IW-1:0]     idx;
  logic [WORD_W-1:0] arr_rdata;

  assign req = mem_read | mem_write;
  assign idx = addr[BYTE_OFF_W +: IW];

  assign fault = (addr[BYTE_OFF_W-1:0] != '0)
               | ({1'b0, addr} >= ADDR_LIMIT)
               | (mem_read & mem_write);

  // State and wait counter; reset may land mid-access and simply abandons it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, wait countdown and raw stall/completion decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_raw = 1'b0;
    done_raw  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            done_raw = 1'b1;
          end else begin
            stall_raw = 1'b1;
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          // CPU withdrew the request: abandon it with no side effects.
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt != 4'd0) begin
          stall_raw = 1'b1;
          cnt_nxt   = cnt - 4'd1;
        end else begin
          done_raw  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // While reset is held every output is forced quiet, even with a request
  // present in IDLE, so the pipeline is never frozen by a held reset.
  assign stall = stall_raw & reset;
  assign done  = done_raw & reset;

  assign we       = done & mem_write & ~fault;
  assign rd_ok    = done & mem_read & ~fault;
  assign addr_err = done & fault;
  assign rdata    = rd_ok ? arr_rdata : '0;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IW          (IW)
  ) u_array (
    .clock (clock),
    .we    (we),
    .idx   (idx),
    .wdata (wdata),
    .rdata (arr_rdata)
  );

`ifdef DMEM_STATS_EN
  // Activity counters; faulting accesses count their stalls but no data op.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_count    <= '0;
      wr_count    <= '0;
      stall_count <= '0;
    end else begin
      if (rd_ok) rd_count    <= rd_count + 32'd1;
      if (we)    wr_count    <= wr_count + 32'd1;
      if (stall) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0
// instance, driven by a vector table, hand-written abort/reset sequences and
// random accesses scored against a word-array reference model.
module tb_dmem_responder;

  localparam int DEPTH = 256;

  logic        clock;
  logic        reset;

  logic        r2, w2, st2, er2;
  logic [31:0] a2, d2, rd2;
  logic        r0, w0, st0, er0;
  logic [31:0] a0, d0, rd0;
`ifdef DMEM_STATS_EN
  logic [31:0] rc2, wc2, sc2, rc0, wc0, sc0;
`endif

  int checks;
  int errors;

  logic [31:0] ref2 [DEPTH];
  logic [31:0] ref0 [DEPTH];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .mem_read(r2), .mem_write(w2),
    .addr(a2), .wdata(d2), .rdata(rd2), .stall(st2), .addr_err(er2)
`ifdef DMEM_STATS_EN
    , .rd_count(rc2), .wr_count(wc2), .stall_count(sc2)
`endif
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset), .mem_read(r0), .mem_write(w0),
    .addr(a0), .wdata(d0), .rdata(rd0), .stall(st0), .addr_err(er0)
`ifdef DMEM_STATS_EN
    , .rd_count(rc0), .wr_count(wc0), .stall_count(sc0)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          sel0;   // 1: WAIT_CYCLES=0 instance
    bit          rd;
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Reference model: rules applied directly to a word array.
  task automatic model_step(input bit sel0, input bit rd, input bit wr,
                            input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] exp_rdata, output bit exp_err);
    bit bad;
    int w;
    bad = (a % 4 != 0) || (a >= DEPTH * 4) || (rd && wr);
    w   = int'(a / 4);
    exp_err   = bad;
    exp_rdata = 32'h0;
    if (!bad && rd) exp_rdata = sel0 ? ref0[w] : ref2[w];
    if (!bad && wr) begin
      if (sel0) ref0[w] = d;
      else      ref2[w] = d;
    end
  endtask

  // Present one request (called just after a rising edge), count stall
  // cycles, sample the completion cycle, then drop the request.
  task automatic access(input bit sel0, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] got_rdata, output bit got_err,
                        output int cycles);
    bit fin;
    fin = 0;
    cycles = 0;
    got_rdata = 32'h0;
    got_err = 0;
    if (sel0) begin r0 = rd; w0 = wr; a0 = a; d0 = d; end
    else      begin r2 = rd; w2 = wr; a2 = a; d2 = d; end
    for (int k = 0; k < 20 && !fin; k++) begin
      @(negedge clock);
      if (sel0 ? st0 : st2) begin
        cycles++;
        @(posedge clock); #1;
      end else begin
        got_rdata = sel0 ? rd0 : rd2;
        got_err   = sel0 ? er0 : er2;
        fin = 1;
      end
    end
    if (!fin) chk("timeout_no_completion", 32'd0, 32'd1);
    @(posedge clock); #1;
    if (sel0) begin r0 = 0; w0 = 0; end
    else      begin r2 = 0; w2 = 0; end
  endtask

  task automatic run_model(input bit sel0, input bit rd, input bit wr,
                           input logic [31:0] a, input logic [31:0] d, input string name);
    logic [31:0] er, gr;
    bit ee, ge;
    int cyc;
    model_step(sel0, rd, wr, a, d, er, ee);
    access(sel0, rd, wr, a, d, gr, ge, cyc);
    chk({name, "_rdata"}, gr, er);
    chk({name, "_err"}, 32'(ge), 32'(ee));
    chk({name, "_stalls"}, 32'(cyc), sel0 ? 32'd0 : 32'd2);
  endtask

  initial begin
    vec_t vecs [14];
    logic [31:0] gr, ra, rdv;
    bit ge, rrd, rwr, rsel;
    int cyc;

    checks = 0;
    errors = 0;

    vecs[0]  = '{0, 0, 1, 32'h10,       32'hDEADBEEF, 0, 32'h0};
    vecs[1]  = '{0, 1, 0, 32'h10,       32'h0,        0, 32'hDEADBEEF};
    vecs[2]  = '{0, 0, 1, 32'h13,       32'hCAFEF00D, 1, 32'h0};
    vecs[3]  = '{0, 1, 0, 32'h10,       32'h0,        0, 32'hDEADBEEF};
    vecs[4]  = '{0, 1, 0, 32'h400,      32'h0,        1, 32'h0};
    vecs[5]  = '{0, 1, 1, 32'h20,       32'h01234567, 1, 32'h0};
    vecs[6]  = '{0, 1, 0, 32'h20,       32'h0,        0, 32'hA5000008};
    vecs[7]  = '{0, 1, 0, 32'h3FC,      32'h0,        0, 32'hA50000FF};
    vecs[8]  = '{0, 0, 1, 32'h3FC,      32'h0F0F0F0F, 0, 32'h0};
    vecs[9]  = '{0, 1, 0, 32'h3FC,      32'h0,        0, 32'h0F0F0F0F};
    vecs[10] = '{0, 1, 0, 32'hFFFFFFFC, 32'h0,        1, 32'h0};
    vecs[11] = '{0, 1, 0, 32'h12,       32'h0,        1, 32'h0};
    vecs[12] = '{1, 0, 1, 32'h04,       32'h12345678, 0, 32'h0};
    vecs[13] = '{1, 1, 0, 32'h04,       32'h0,        0, 32'h12345678};

    // Reset held with a read request present: outputs must stay quiet.
    reset = 0;
    r2 = 1; w2 = 0; a2 = 32'h10; d2 = 0;
    r0 = 1; w0 = 0; a0 = 32'h10; d0 = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_stall", 32'(st2), 32'd0);
    chk("reset_err", 32'(er2), 32'd0);
    chk("reset_rdata", rd2, 32'h0);
    chk("reset_stall_wc0", 32'(st0), 32'd0);
    chk("reset_rdata_wc0", rd0, 32'h0);
`ifdef DMEM_STATS_EN
    chk("reset_stall_count", sc2, 32'd0);
    chk("reset_rd_count", rc2, 32'd0);
`endif
    r2 = 0; r0 = 0;
    reset = 1;
    @(posedge clock); #1;

    // Fill both memories with a known pattern.
    for (int i = 0; i < DEPTH; i++) begin
      ref2[i] = 32'hA5000000 | 32'(i);
      ref0[i] = 32'h5A000000 | 32'(i);
      access(0, 0, 1, 32'(i * 4), ref2[i], gr, ge, cyc);
      access(1, 0, 1, 32'(i * 4), ref0[i], gr, ge, cyc);
    end

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      logic [31:0] er;
      bit ee;
      model_step(vecs[i].sel0, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, er, ee);
      access(vecs[i].sel0, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, gr, ge, cyc);
      chk($sformatf("vec%0d_rdata", i), gr, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(ge), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_stalls", i), 32'(cyc), vecs[i].sel0 ? 32'd0 : 32'd2);
    end

    // Abort: request withdrawn during WAIT leaves memory untouched.
    w2 = 1; a2 = 32'h40; d2 = 32'h11112222;
    @(negedge clock);
    chk("abort_stall_first", 32'(st2), 32'd1);
    @(posedge clock); #1;
    w2 = 0;
    @(negedge clock);
    chk("abort_stall_dropped", 32'(st2), 32'd0);
    chk("abort_err", 32'(er2), 32'd0);
    @(posedge clock); #1;
    run_model(0, 1, 0, 32'h40, 32'h0, "abort_readback");

    // Reset during the first wait cycle of a write to 0x30.
    w2 = 1; a2 = 32'h30; d2 = 32'hBAD0BAD0;
    @(negedge clock);
    chk("rstmid_stall_before", 32'(st2), 32'd1);
    @(posedge clock); #1;
    reset = 0;
    #1;
    chk("rstmid_stall_now", 32'(st2), 32'd0);
    chk("rstmid_err_now", 32'(er2), 32'd0);
    @(posedge clock); #1;
    w2 = 0;
    @(negedge clock);
    reset = 1;
    @(posedge clock); #1;

    // 3 reads, 2 writes, 1 fault right after reset (first read proves IDLE
    // and the old 0x30 contents).
    run_model(0, 1, 0, 32'h30, 32'h0, "post_rst_read30");
    run_model(0, 1, 0, 32'h10, 32'h0, "stats_rd2");
    run_model(0, 1, 0, 32'h04, 32'h0, "stats_rd3");
    run_model(0, 0, 1, 32'h50, 32'h77778888, "stats_wr1");
    run_model(0, 0, 1, 32'h54, 32'h9999AAAA, "stats_wr2");
    run_model(0, 1, 0, 32'h401, 32'h0, "stats_fault");
`ifdef DMEM_STATS_EN
    chk("rd_count", rc2, 32'd3);
    chk("wr_count", wc2, 32'd2);
    chk("stall_count", sc2, 32'd12);
`endif

    // Random accesses against the reference model.
    for (int i = 0; i < 80; i++) begin
      int kind;
      int op;
      rsel = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 7);
      op   = $urandom_range(0, 4);
      case (kind)
        5:       ra = {22'($urandom_range(0, 1023)), 10'h0} | 32'($urandom_range(0, 1023)) | 32'h1;
        6:       ra = {$urandom_range(256, 32'h3FFFFFFF), 2'b00};
        7:       ra = $urandom;
        default: ra = {22'h0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
      endcase
      rrd = (op == 0) || (op == 2) || (op == 4);
      rwr = (op == 1) || (op == 2) || (op == 3);
      rdv = $urandom;
      run_model(rsel, rrd, rwr, ra, rdv, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Multi-cycle data-memory responder on the MEM-stage load/store interface of the pipelined CPU. It replaces the single-cycle data memory. It accepts the CPU's read/write request, inserts WAIT_CYCLES wait states, and back-pressures the pipeline through stall. Stores are committed and load data is returned only on the completion cycle. Misaligned and out-of-range accesses are flagged.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; legal byte addresses are 0 .. DEPTH_WORDS*4-1.
WAIT_CYCLES, 2, stall cycles inserted per access; 0 gives single-cycle behaviour. Legal range 0..15.

Ports:
clock  input  1  system clock, all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset; asserted when reset=0.
mem_read  input  1  load request; held stable by the CPU while stall=1.
mem_write  input  1  store request; held stable by the CPU while stall=1.
addr  input  32  byte address, from the EX/MEM ALU result.
wdata  input  32  store data.
rdata  output  32  load data; valid only on a read completion cycle.
stall  output  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM while 1.
addr_err  output  1  combinational; 1 on the completion cycle of a faulting access.

Behaviour:
- Request present: req = mem_read | mem_write.
- States: IDLE and WAIT, plus a 4-bit counter cnt.
- IDLE, req=1, WAIT_CYCLES=0: the access completes this cycle; stall=0.
- IDLE, req=1, WAIT_CYCLES>0: stall=1; next state WAIT with cnt=WAIT_CYCLES-1.
- WAIT, req=1, cnt>0: stall=1; cnt decrements.
- WAIT, req=1, cnt=0: completion cycle; stall=0; next state IDLE.
- Latency: a request occupies exactly WAIT_CYCLES+1 cycles. Back-to-back requests each pay the full latency; there is no pipelining of accesses.
- Completion cycle, read: rdata = mem[addr[ADDR_W-1:2]] (combinational read).
- Completion cycle, write: mem[idx] <= wdata at the closing rising edge.
- Outside a read completion cycle: rdata = 32'h0.
- Fault conditions: addr[1:0] != 0, or addr >= DEPTH_WORDS*4, or mem_read and mem_write both set.
- On a fault: addr_err=1 on the completion cycle only; the write is suppressed; rdata=0.
- A faulting access still takes the full latency.
- Abort: if req drops to 0 while in WAIT, return to IDLE next edge with stall=0; no write occurs. The address is not compared across cycles, so the CPU must hold it stable.
- Reset (async, any time, including mid-access): state=IDLE, cnt=0.
- While reset=0: stall=0, addr_err=0, rdata=0.
- Memory contents are not cleared by reset.
- Index arithmetic: idx = addr[2+IW-1:2], with IW = clog2(DEPTH_WORDS). The range check uses the full 32-bit address, so no aliasing occurs.

Optional Feature:
Macro DMEM_STATS_EN.
- Defined: adds three output ports.
  - rd_count[31:0]: incremented on each successful read completion.
  - wr_count[31:0]: incremented on each successful write completion.
  - stall_count[31:0]: incremented on every cycle with stall=1.
- All three counters are async-reset to 0 and wrap modulo 2^32. Faulting accesses increment stall_count but neither rd_count nor wr_count.
- Undefined: the ports and counters are absent; core behaviour is identical.

Decomposition:
- Package dmem_pkg holds:
  - state encoding: IDLE=1'b0, WAIT=1'b1;
  - WORD_W=32;
  - BYTE_OFF_W=2;
  - a function for clog2.
- Sub-module dmem_array (parameter DEPTH_WORDS): synchronous write enable, asynchronous read, no reset.
- FSM, counter, fault logic and stats stay in dmem_responder.

Test Plan:
- WAIT_CYCLES=2; write addr=0x10, wdata=0xDEADBEEF held → stall=1,1 then 0. The word is written at the third edge. A following read of 0x10 → stall=1,1 then rdata=0xDEADBEEF, addr_err=0.
- WAIT_CYCLES=0; read 0x04 after writing 0x12345678 there → rdata=0x12345678 in the same cycle, stall never asserted.
- Misaligned write addr=0x13 → addr_err=1 on the completion cycle, stall for 2 cycles. A subsequent read of 0x10 still returns the prior value.
- Read addr=0x400 with DEPTH_WORDS=256 → addr_err=1, rdata=0. Both mem_read and mem_write set at 0x20 → addr_err=1, no write.
- Drive reset=0 during the first wait cycle of a write to 0x30 → stall=0 immediately. After reset=1, a read of 0x30 shows the old value and the FSM is in IDLE.
- With DMEM_STATS_EN, run 3 reads, 2 writes and 1 fault at WAIT_CYCLES=2 → rd_count=3, wr_count=2, stall_count=12.
